// File: rtl/fp32_addsub_seq_if.sv
// Request/response bundle for the sequential FP32 add/sub unit.
// The master modport is the issuing side, which also consumes the result.
interface fp32_addsub_seq_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_float_A;
    logic [31:0] i_float_B;
    logic        i_sub_mode;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_overflow;
    logic        o_zero;
    logic        o_NaN;

    modport master (
        output i_valid, i_float_A, i_float_B, i_sub_mode, i_ready,
        input  o_ready, o_valid, o_result, o_overflow, o_zero, o_NaN
    );

    modport slave (
        input  i_valid, i_float_A, i_float_B, i_sub_mode, i_ready,
        output o_ready, o_valid, o_result, o_overflow, o_zero, o_NaN
    );
endinterface

// File: rtl/fp32_addsub_seq.sv
// Multi-cycle FP32 add/sub: UNPACK, ALIGN (shift + add), iterative NORM, ROUND, DONE.
// Define FP_ROUND_RNE_EN for round-to-nearest-even; otherwise ROUND truncates.
module fp32_addsub_seq #(
    parameter int          NORM_STEP = 1,
    parameter logic [31:0] QNAN      = 32'h7FC00000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fp32_addsub_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [4:0] STEP = 5'(NORM_STEP);

    state_t             state_r, state_s;
    logic [31:0]        a_r, a_s, b_r, b_s;
    logic               sub_r, sub_s, sign_r, sign_s, eff_sub_r, eff_sub_s;
    logic signed [9:0]  exp_r, exp_s;
    logic [26:0]        x_r, x_s, y_r, y_s;
    logic [7:0]         diff_r, diff_s;
    logic [27:0]        sum_r, sum_s;
    logic               ready_r, ready_s, valid_r, valid_s;
    logic [31:0]        result_r, result_s;
    logic               ovf_r, ovf_s, zero_r, zero_s, nan_r, nan_s;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Operand classification; subnormals count as zero and keep their sign.
    logic [7:0]  ea_s, eb_s;
    logic [22:0] ma_s, mb_s;
    logic        sa_s, sb_s, zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s, any_nan_s;
    logic [30:0] mag_a_s, mag_b_s;
    logic [26:0] ua_s, ub_s;
    assign ea_s      = a_r[30:23];
    assign eb_s      = b_r[30:23];
    assign ma_s      = a_r[22:0];
    assign mb_s      = b_r[22:0];
    assign sa_s      = a_r[31];
    assign sb_s      = b_r[31] ^ sub_r;
    assign zero_a_s  = (ea_s == 8'd0);
    assign zero_b_s  = (eb_s == 8'd0);
    assign inf_a_s   = (ea_s == 8'hFF) && (ma_s == 23'd0);
    assign inf_b_s   = (eb_s == 8'hFF) && (mb_s == 23'd0);
    assign nan_a_s   = (ea_s == 8'hFF) && (ma_s != 23'd0);
    assign nan_b_s   = (eb_s == 8'hFF) && (mb_s != 23'd0);
    assign any_nan_s = nan_a_s | nan_b_s | (inf_a_s & inf_b_s & (sa_s ^ sb_s));
    assign mag_a_s   = zero_a_s ? 31'd0 : a_r[30:0];
    assign mag_b_s   = zero_b_s ? 31'd0 : b_r[30:0];
    assign ua_s      = {~zero_a_s, (zero_a_s ? 23'd0 : ma_s), 3'b000};
    assign ub_s      = {~zero_b_s, (zero_b_s ? 23'd0 : mb_s), 3'b000};

    // Right-shift the smaller operand, folding every lost bit into sticky.
    logic [26:0] y_sh_s, y_mask_s, y_al_s;
    always_comb begin
        y_sh_s   = y_r >> diff_r[4:0];
        y_mask_s = (27'd1 << diff_r[4:0]) - 27'd1;
        if (diff_r >= 8'd27) y_al_s = {26'd0, |y_r};
        else                 y_al_s = {y_sh_s[26:1], y_sh_s[0] | (|(y_r & y_mask_s))};
    end

    // Per-cycle left-shift amount, capped at NORM_STEP.
    logic [4:0] lz_s, step_s;
    always_comb begin
        lz_s = lzc27(sum_r[26:0]);
        if (lz_s < STEP) step_s = lz_s;
        else             step_s = STEP;
    end

    // Drop G/R/S; a mantissa carry bumps the exponent.
    logic               rnd_up_s;
    logic [24:0]        rmant_s;
    logic signed [9:0]  rexp_s;
    logic [22:0]        rfrac_s;
    always_comb begin
`ifdef FP_ROUND_RNE_EN
        rnd_up_s = sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
`else
        rnd_up_s = 1'b0;
`endif
        rmant_s = {1'b0, sum_r[26:3]} + {24'd0, rnd_up_s};
        rexp_s  = exp_r + $signed({9'd0, rmant_s[24]});
        if (rmant_s[24]) rfrac_s = rmant_s[23:1];
        else             rfrac_s = rmant_s[22:0];
    end

    // Next-state and next-output logic; everything holds unless a state moves it.
    always_comb begin
        state_s = state_r;  a_s = a_r;  b_s = b_r;  sub_s = sub_r;
        sign_s = sign_r;  exp_s = exp_r;  x_s = x_r;  y_s = y_r;
        diff_s = diff_r;  eff_sub_s = eff_sub_r;  sum_s = sum_r;
        ready_s = ready_r;  valid_s = valid_r;  result_s = result_r;
        ovf_s = ovf_r;  zero_s = zero_r;  nan_s = nan_r;
        case (state_r)
            S_IDLE: begin
                if (bus.i_valid) begin
                    a_s = bus.i_float_A;  b_s = bus.i_float_B;  sub_s = bus.i_sub_mode;
                    ready_s = 1'b0;
                    state_s = S_UNPACK;
                end else begin
                    ready_s = 1'b1;
                end
            end
            S_UNPACK: begin
                if (any_nan_s) begin
                    result_s = QNAN;  nan_s = 1'b1;  valid_s = 1'b1;  state_s = S_DONE;
                end else if (inf_a_s | inf_b_s) begin
                    result_s = {(inf_a_s ? sa_s : sb_s), 8'hFF, 23'd0};
                    ovf_s = 1'b1;  valid_s = 1'b1;  state_s = S_DONE;
                end else if (zero_a_s & zero_b_s) begin
                    result_s = {sa_s & sb_s, 31'd0};
                    zero_s = 1'b1;  valid_s = 1'b1;  state_s = S_DONE;
                end else begin
                    if (mag_a_s >= mag_b_s) begin
                        x_s = ua_s;  y_s = ub_s;  sign_s = sa_s;
                        exp_s = $signed({2'b00, ea_s});  diff_s = ea_s - eb_s;
                    end else begin
                        x_s = ub_s;  y_s = ua_s;  sign_s = sb_s;
                        exp_s = $signed({2'b00, eb_s});  diff_s = eb_s - ea_s;
                    end
                    eff_sub_s = sa_s ^ sb_s;
                    state_s   = S_ALIGN;
                end
            end
            // Alignment and the 28-bit add share this cycle; |X| >= |Y| keeps the sum non-negative.
            S_ALIGN: begin
                if (eff_sub_r) sum_s = {1'b0, x_r} - {1'b0, y_al_s};
                else           sum_s = {1'b0, x_r} + {1'b0, y_al_s};
                state_s = S_NORM;
            end
            S_NORM: begin
                if (sum_r == 28'd0) begin
                    result_s = 32'd0;  zero_s = 1'b1;  valid_s = 1'b1;  state_s = S_DONE;
                end else if (sum_r[27]) begin
                    sum_s   = {1'b0, sum_r[27:2], sum_r[1] | sum_r[0]};
                    exp_s   = exp_r + 10'sd1;
                    state_s = S_ROUND;
                end else if (sum_r[26]) begin
                    if (exp_r <= 10'sd0) begin
                        result_s = {sign_r, 31'd0};  zero_s = 1'b1;  valid_s = 1'b1;  state_s = S_DONE;
                    end else begin
                        state_s = S_ROUND;
                    end
                end else begin
                    sum_s = {1'b0, sum_r[26:0] << step_s};
                    exp_s = exp_r - $signed({5'd0, step_s});
                end
            end
            S_ROUND: begin
                if (rexp_s >= 10'sd255) begin
                    result_s = {sign_r, 8'hFF, 23'd0};  ovf_s = 1'b1;
                end else begin
                    result_s = {sign_r, rexp_s[7:0], rfrac_s};
                end
                valid_s = 1'b1;
                state_s = S_DONE;
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    valid_s = 1'b0;  result_s = 32'd0;
                    ovf_s = 1'b0;  zero_s = 1'b0;  nan_s = 1'b0;
                    ready_s = 1'b1;  state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                valid_s = 1'b0;  result_s = 32'd0;
                ovf_s = 1'b0;  zero_s = 1'b0;  nan_s = 1'b0;
                ready_s = 1'b1;  state_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset drops any in-flight op.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_IDLE;  a_r <= 32'd0;  b_r <= 32'd0;  sub_r <= 1'b0;
            sign_r <= 1'b0;  exp_r <= 10'sd0;  x_r <= 27'd0;  y_r <= 27'd0;
            diff_r <= 8'd0;  eff_sub_r <= 1'b0;  sum_r <= 28'd0;
            ready_r <= 1'b1;  valid_r <= 1'b0;  result_r <= 32'd0;
            ovf_r <= 1'b0;  zero_r <= 1'b0;  nan_r <= 1'b0;
        end else begin
            state_r <= state_s;  a_r <= a_s;  b_r <= b_s;  sub_r <= sub_s;
            sign_r <= sign_s;  exp_r <= exp_s;  x_r <= x_s;  y_r <= y_s;
            diff_r <= diff_s;  eff_sub_r <= eff_sub_s;  sum_r <= sum_s;
            ready_r <= ready_s;  valid_r <= valid_s;  result_r <= result_s;
            ovf_r <= ovf_s;  zero_r <= zero_s;  nan_r <= nan_s;
        end
    end

    assign bus.o_ready    = ready_r;
    assign bus.o_valid    = valid_r;
    assign bus.o_result   = result_r;
    assign bus.o_overflow = ovf_r;
    assign bus.o_zero     = zero_r;
    assign bus.o_NaN      = nan_r;
endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Directed bench for fp32_addsub_seq: hand-computed results, flags and latencies.
// Flags are compared as {o_overflow, o_zero, o_NaN}.
module tb_fp32_addsub_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp32_addsub_seq_if bus();
    fp32_addsub_seq dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    // Issue one op at posedge+1; returns at the negedge of the first o_valid cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] res, output logic [2:0] flg,
                         output int lat, output logic rdy);
        bus.i_float_A = a;  bus.i_float_B = b;  bus.i_sub_mode = s;  bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = -1;  res = 32'h0;  flg = 3'b000;  rdy = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                lat = n;  res = bus.o_result;  rdy = bus.o_ready;
                flg = {bus.o_overflow, bus.o_zero, bus.o_NaN};
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_result();
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;  bus.i_valid = 1'b0;  bus.i_ready = 1'b0;
        bus.i_float_A = 32'h0;  bus.i_float_B = 32'h0;  bus.i_sub_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
        n_vec++;
        if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_vec++;
        if (bus.o_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h expected 00000000", bus.o_result); end
        n_vec++;
        if ({bus.o_overflow, bus.o_zero, bus.o_NaN} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 000", {bus.o_overflow, bus.o_zero, bus.o_NaN});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        vec_t v[8];
        logic [31:0] res;  logic [2:0] flg;  int lat;  logic rdy;
        v[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 5};
        v[1] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000, 6};
        v[2] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 6};
        v[3] = '{32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 3'b000, 5};
        v[4] = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000, 5};
        v[5] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 28};
        v[6] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b010, -1};
        v[7] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 3'b000, 5};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, res, flg, lat, rdy);
            n_vec++;
            if (res !== v[i].r) begin n_bad++; $display("FAIL arith[%0d]_result: got %h expected %h", i, res, v[i].r); end
            n_vec++;
            if (flg !== v[i].f) begin n_bad++; $display("FAIL arith[%0d]_flags: got %b expected %b", i, flg, v[i].f); end
            if (v[i].lat >= 0) begin
                n_vec++;
                if (lat !== v[i].lat) begin n_bad++; $display("FAIL arith[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
            end
            n_vec++;
            if (rdy !== 1'b0) begin n_bad++; $display("FAIL arith[%0d]_ready_in_done: got %b expected 0", i, rdy); end
            release_result();
        end
    endtask

    task automatic test_exceptions();
        vec_t v[12];
        logic [31:0] res;  logic [2:0] flg;  int lat;  logic rdy;
        v[0]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 2};
        v[1]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 2};
        v[2]  = '{32'hFF800000, 32'h7F800000, 1'b0, 32'h7FC00000, 3'b001, 2};
        v[3]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b100, 2};
        v[4]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b100, 2};
        v[5]  = '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b100, 2};
        v[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b010, 2};
        v[7]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b010, 2};
        v[8]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b010, 2};
        v[9]  = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b010, 2};
        v[10] = '{32'h00000001, 32'h80000001, 1'b0, 32'h00000000, 3'b010, 2};
        v[11] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 5};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, res, flg, lat, rdy);
            n_vec++;
            if (res !== v[i].r) begin n_bad++; $display("FAIL exc[%0d]_result: got %h expected %h", i, res, v[i].r); end
            n_vec++;
            if (flg !== v[i].f) begin n_bad++; $display("FAIL exc[%0d]_flags: got %b expected %b", i, flg, v[i].f); end
            n_vec++;
            if (lat !== v[i].lat) begin n_bad++; $display("FAIL exc[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
            release_result();
        end
    endtask

    task automatic test_rounding();
        vec_t v[3];
        logic [31:0] res;  logic [2:0] flg;  int lat;  logic rdy;
`ifdef FP_ROUND_RNE_EN
        v[0] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000, 5};
        v[2] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000, 5};
`else
        v[0] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b000, 5};
        v[2] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 3'b000, 5};
`endif
        v[1] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 5};
        for (int i = 0; i < 3; i++) begin
            do_op(v[i].a, v[i].b, v[i].s, res, flg, lat, rdy);
            n_vec++;
            if (res !== v[i].r) begin n_bad++; $display("FAIL round[%0d]_result: got %h expected %h", i, res, v[i].r); end
            n_vec++;
            if (lat !== v[i].lat) begin n_bad++; $display("FAIL round[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;  logic [2:0] flg;  int lat;  logic rdy;
        do_op(32'h3F800000, 32'h40000000, 1'b0, res, flg, lat, rdy);
        n_vec++;
        if (res !== 32'h40400000) begin n_bad++; $display("FAIL bp_first: got %h expected 40400000", res); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if ({bus.o_valid, bus.o_ready, bus.o_result} !== {1'b1, 1'b0, 32'h40400000}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b result=%h expected valid=1 ready=0 result=40400000",
                         k, bus.o_valid, bus.o_ready, bus.o_result);
            end
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.o_valid, bus.o_ready, bus.o_result, bus.o_overflow, bus.o_zero, bus.o_NaN} !==
            {1'b0, 1'b1, 32'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL bp_release: got valid=%b ready=%b result=%h expected valid=0 ready=1 result=00000000",
                     bus.o_valid, bus.o_ready, bus.o_result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.i_float_A = 32'h3F800001;  bus.i_float_B = 32'h3F800000;  bus.i_sub_mode = 1'b1;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.o_ready, bus.o_valid} !== 2'b10) begin
            n_bad++; $display("FAIL midreset_idle: got ready=%b valid=%b expected ready=1 valid=0", bus.o_ready, bus.o_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_valid: got %b expected 0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;  logic [2:0] flg;  int lat;  logic rdy;
        do_op(32'h40400000, 32'h3F800000, 1'b0, res, flg, lat, rdy);
        n_vec++;
        if (res !== 32'h40800000) begin n_bad++; $display("FAIL b2b_first: got %h expected 40800000", res); end
        release_result();
        n_vec++;
        if ({bus.o_ready, bus.o_valid} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_idle: got ready=%b valid=%b expected ready=1 valid=0", bus.o_ready, bus.o_valid);
        end
        do_op(32'hC0400000, 32'h3F800000, 1'b0, res, flg, lat, rdy);
        n_vec++;
        if (res !== 32'hC0000000) begin n_bad++; $display("FAIL b2b_second: got %h expected C0000000", res); end
        n_vec++;
        if (lat !== 5) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_exceptions();
        test_rounding();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
